main_control_fsm: RTL

//  Multi-cycle main control unit for the RV32 subset datapath (R-type add/sub/and/or, lw, sw, beq).

---
 rtl/main_control_fsm.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/main_control_fsm.sv
// Multi-cycle main control FSM for the RV32 subset datapath (R-type, lw, sw, beq).
// Optional INSTR_COUNT_EN adds a retired-instruction counter output.
module main_control_fsm #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [1:0] aluOp,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic       memRead,
  output logic       memWrite,
  output logic       iorD,
  output logic       irWrite,
  output logic       pcWrite,
  output logic       pcSrc,
  output logic       regWrite,
  output logic       memToReg,
  output logic       trap,
  output logic [3:0] state_o
`ifdef INSTR_COUNT_EN
  ,
  output logic [31:0] instr_count
`endif
);

  localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_LIMIT = CW'(MEM_TIMEOUT - 1);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    EXR    = 4'd3,
    ADDR   = 4'd4,
    BEQ    = 4'd5,
    MRD    = 4'd6,
    MWR    = 4'd7,
    WBR    = 4'd8,
    WBL    = 4'd9,
    TRAP   = 4'd15
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] wait_cnt;
  logic          mem_wait;
  logic          timeout;
  logic          instr_done;

  assign mem_wait = (state == FETCH) || (state == MRD) || (state == MWR);
  assign timeout  = (wait_cnt == WAIT_LIMIT) && !mem_ready;
  assign state_o  = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Counter restarts whenever a new state is entered, so back-to-back
  // memory states each get a full wait budget.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       wait_cnt <= '0;
    else if (state_next != state)    wait_cnt <= '0;
    else if (mem_wait && !mem_ready) wait_cnt <= wait_cnt + 1'b1;
  end

  always_comb begin
    state_next = state;
    instr_done = 1'b0;
    aluOp      = 2'b00;
    aluSrcA    = 1'b0;
    aluSrcB    = 2'b00;
    memRead    = 1'b0;
    memWrite   = 1'b0;
    iorD       = 1'b0;
    irWrite    = 1'b0;
    pcWrite    = 1'b0;
    pcSrc      = 1'b0;
    regWrite   = 1'b0;
    memToReg   = 1'b0;
    trap       = 1'b0;

    case (state)
      IDLE: begin
        if (run) state_next = FETCH;
      end
      FETCH: begin
        memRead = 1'b1;
        aluSrcB = 2'b01;
        if (mem_ready) begin
          irWrite    = 1'b1;
          pcWrite    = 1'b1;
          state_next = DECODE;
        end else if (timeout) begin
          state_next = TRAP;
        end
      end
      DECODE: begin
        aluSrcB = 2'b10;
        case (opcode)
          OP_R:         state_next = EXR;
          OP_LW, OP_SW: state_next = ADDR;
          OP_BEQ:       state_next = BEQ;
          default:      state_next = TRAP;
        endcase
      end
      EXR: begin
        aluSrcA    = 1'b1;
        aluOp      = 2'b10;
        state_next = WBR;
      end
      ADDR: begin
        aluSrcA    = 1'b1;
        aluSrcB    = 2'b10;
        state_next = (opcode == OP_SW) ? MWR : MRD;
      end
      BEQ: begin
        aluSrcA    = 1'b1;
        aluOp      = 2'b01;
        pcSrc      = 1'b1;
        pcWrite    = zero;
        instr_done = 1'b1;
      end
      MRD: begin
        memRead = 1'b1;
        iorD    = 1'b1;
        if (mem_ready)    state_next = WBL;
        else if (timeout) state_next = TRAP;
      end
      MWR: begin
        memWrite = 1'b1;
        iorD     = 1'b1;
        if (mem_ready)    instr_done = 1'b1;
        else if (timeout) state_next = TRAP;
      end
      WBR: begin
        regWrite   = 1'b1;
        instr_done = 1'b1;
      end
      WBL: begin
        regWrite   = 1'b1;
        memToReg   = 1'b1;
        instr_done = 1'b1;
      end
      TRAP: begin
        trap = 1'b1;
      end
      // Unused encodings are treated as a fault rather than silently recovered.
      default: state_next = TRAP;
    endcase

    if (instr_done) state_next = run ? FETCH : IDLE;
  end

`ifdef INSTR_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           instr_count <= '0;
    else if (instr_done) instr_count <= instr_count + 32'd1;
  end
`endif

endmodule
